mux_rr_arb: RTL
===============

// Module: mux_rr_arb
//
// PURPOSE
//   Parametrised N-channel, W-bit multiplexer with round-robin arbitration,
//   val/rdy handshakes on every input and on the output, and a one-entry
//   registered output stage.
//   Replaces fixed 2:1 steering muxes wherever several producers share one
//   consumer. Fairness is guaranteed by a rotating priority pointer.
//
// PARAMETERS
//   p_nbits  4  data width of each channel, in bits (>=1)
//   p_nchan  4  number of input channels (>=2)
//
// PORTS
//   clk       in   1                clock; all state updates on rising edge
//   rst_n     in   1                asynchronous active-low reset
//   in_val    in   p_nchan          per-channel valid
//   in_rdy    out  p_nchan          per-channel ready (at most one bit set)
//   in_data   in   p_nchan*p_nbits  channel i occupies bits [i*p_nbits +: p_nbits]
//   out_val   out  1                output register holds a beat
//   out_rdy   in   1                consumer accepts the beat
//   out_data  out  p_nbits          registered data
//   out_chan  out  $clog2(p_nchan)  source channel of out_data
//
// BEHAVIOUR
//   - Clock and reset: one clock. Reset is asynchronous and active-low.
//   - Reset values: out_val=0, out_data=0, out_chan=0, ptr=0.
//     in_rdy is all zeros while rst_n=0.
//   - Reset mid-operation: a held beat is discarded. No beat is emitted
//     in the first cycle after rst_n deasserts.
//   - Grant: the first i with in_val[i]=1, searching ptr, ptr+1, ... and
//     wrapping modulo p_nchan. The grant is zero if no input is valid.
//   - Ready: en = !out_val | out_rdy. in_rdy[i] = grant[i] & en.
//     in_rdy is combinational from in_val, out_val and out_rdy.
//     in_val must never depend on in_rdy.
//   - Accept: a transfer occurs when in_val[i] & in_rdy[i].
//     On the next edge: out_data <= channel i data, out_chan <= i, out_val <= 1,
//     ptr <= (i+1) mod p_nchan. Latency is 1 cycle.
//   - Drain: out_val & out_rdy with no accept in that cycle gives out_val <= 0.
//     Drain and accept in the same cycle gives back-to-back beats at full
//     throughput.
//   - Stall: out_val & !out_rdy holds out_data and out_chan stable,
//     forces all in_rdy=0, and freezes ptr.
//   - Empty: ptr does not change in cycles with no accept.
//   - Wrap-around: when the accepted channel is p_nchan-1, ptr becomes 0.
//   - Width: no arithmetic is performed on data. The ptr increment is
//     computed in $clog2(p_nchan)+1 bits, then wrapped.
//     p_nchan need not be a power of 2.
//
// CONFIGURATION
//   MUX_RR_LOCK_EN defined:
//     - Adds an input port in_last (p_nchan bits).
//     - After a channel is accepted with in_last[i]=0, the arbiter locks to
//       that channel. Other channels get in_rdy=0 even when the locked
//       channel is idle.
//     - The lock releases when a beat with in_last[i]=1 is accepted;
//       ptr advances only at that point.
//     - Reset clears the lock.
//   MUX_RR_LOCK_EN undefined:
//     - No in_last port. Every beat is arbitrated independently.
//
// STRUCTURE
//   - Package mux_rr_pkg: function clog2_min1(n), which returns max(1,$clog2(n)),
//     and typedef-free helpers for the channel-index width.
//   - Sub-module rr_arbiter: combinational. Inputs are req[p_nchan] and
//     ptr; output is a one-hot grant. This is where the rotating-priority
//     search lives.
//   - mux_rr_arb contains the pointer register, the optional lock FSM
//     (states IDLE/LOCKED), the data mux and the output register.
//
// TESTING  (p_nbits=4, p_nchan=4 unless noted)
//   1. Reset: rst_n=0 mid-beat, then release.
//      -> out_val=0, out_data=0, out_chan=0, in_rdy=0000 immediately;
//         the first accept after release uses ptr=0.
//   2. in_val=1111 held, data ch i = 4'hA+i, out_rdy=1.
//      -> out_chan sequence 0,1,2,3,0, data A,B,C,D,A, one beat per cycle.
//   3. Only ch2 valid (data 4'h5), out_rdy=0 for 3 cycles, then 1.
//      -> out_val=1, out_data=5 held 3 cycles, in_rdy=0000 during the stall,
//         then one more beat is accepted.
//   4. p_nchan=3: ch2 accepted, then ch0 and ch1 both valid.
//      -> ptr wraps to 0, ch0 granted before ch1.
//   5. MUX_RR_LOCK_EN: ch1 sends 3 beats with in_last=0,0,1 while ch0 and
//      ch3 are valid.
//      -> out_chan=1,1,1, then ch3 granted (ptr=2).
//   6. Random val/rdy for 1000 cycles against a reference model.
//      -> no beat lost or duplicated, and the per-channel wait is bounded
//         by p_nchan accepts.

Source files
------------

// File: rtl/mux_rr_pkg.sv
// Shared helpers for the round-robin multiplexer: channel-index width and lock FSM states.
package mux_rr_pkg;

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} lock_state_t;

  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_rr_arb_rr_arbiter.sv
// Combinational rotating-priority arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter
  import mux_rr_pkg::*;
#(
  parameter int p_nchan = 4,
  parameter int CW      = clog2_min1(p_nchan)
) (
  input  logic [p_nchan-1:0] req,
  input  logic [CW-1:0]      ptr,
  output logic [p_nchan-1:0] grant
);

  logic [CW:0] idx;
  logic        found;

  // ptr + k is at most 2*p_nchan-2, so one conditional subtract wraps it
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < p_nchan; k++) begin
      idx = {1'b0, ptr} + (CW+1)'(k);
      if (idx >= (CW+1)'(p_nchan)) idx = idx - (CW+1)'(p_nchan);
      if (!found && req[idx[CW-1:0]]) begin
        grant[idx[CW-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arb.sv
// N-channel val/rdy multiplexer with round-robin arbitration and a one-entry output register.
// Define MUX_RR_LOCK_EN to add in_last and hold the grant on one channel until its last beat.
module mux_rr_arb
  import mux_rr_pkg::*;
#(
  parameter int p_nbits = 4,
  parameter int p_nchan = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [p_nchan-1:0]           in_val,
  output logic [p_nchan-1:0]           in_rdy,
  input  logic [p_nchan*p_nbits-1:0]   in_data,
`ifdef MUX_RR_LOCK_EN
  input  logic [p_nchan-1:0]           in_last,
`endif
  output logic                         out_val,
  input  logic                         out_rdy,
  output logic [p_nbits-1:0]           out_data,
  output logic [$clog2(p_nchan)-1:0]   out_chan
);

  localparam int CW = clog2_min1(p_nchan);

  logic [CW-1:0]      ptr;
  logic [CW-1:0]      ptr_nxt;
  logic [CW:0]        ptr_inc;
  logic [p_nchan-1:0] req;
  logic [p_nchan-1:0] grant;
  logic [p_nchan-1:0] lock_mask;
  logic [CW-1:0]      acc_idx;
  logic [p_nbits-1:0] data_sel;
  logic               en;
  logic               accept;
  logic               last_acc;
  logic               vld_p1;
  logic [p_nbits-1:0] data_p1;
  logic [CW-1:0]      chan_p1;

  // Stage 0: arbitration, ready generation and source selection
  assign en     = !vld_p1 || out_rdy;
  assign req    = in_val & lock_mask;
  assign in_rdy = (rst_n && en) ? grant : '0;
  assign accept = |(in_val & in_rdy);

  rr_arbiter #(
    .p_nchan (p_nchan),
    .CW      (CW)
  ) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (grant)
  );

  always_comb begin
    acc_idx  = '0;
    data_sel = '0;
    for (int i = 0; i < p_nchan; i++) begin
      if (grant[i]) begin
        acc_idx  = CW'(i);
        data_sel = in_data[i*p_nbits +: p_nbits];
      end
    end
  end

  always_comb begin
    ptr_inc = {1'b0, acc_idx} + (CW+1)'(1);
    ptr_nxt = (ptr_inc == (CW+1)'(p_nchan)) ? '0 : ptr_inc[CW-1:0];
  end

`ifdef MUX_RR_LOCK_EN
  lock_state_t   state;
  lock_state_t   state_nxt;
  logic [CW-1:0] lock_chan;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      lock_chan <= '0;
    end else begin
      state <= state_nxt;
      if (accept) lock_chan <= acc_idx;
    end
  end

  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = in_last[acc_idx] ? ST_IDLE : ST_LOCKED;
  end

  // While locked only the owning channel may request, even if it is idle
  always_comb begin
    lock_mask = '1;
    if (state == ST_LOCKED) begin
      lock_mask            = '0;
      lock_mask[lock_chan] = 1'b1;
    end
  end

  assign last_acc = in_last[acc_idx];
`else
  assign lock_mask = '1;
  assign last_acc  = 1'b1;
`endif

  // Stage 1: priority pointer and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      chan_p1 <= '0;
    end else begin
      if (accept && last_acc) ptr <= ptr_nxt;
      if (accept) begin
        vld_p1  <= 1'b1;
        data_p1 <= data_sel;
        chan_p1 <= acc_idx;
      end else if (out_rdy) begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign out_val  = vld_p1;
  assign out_data = data_p1;
  assign out_chan = chan_p1;

endmodule
